// File: rtl/ram_dp_arbiter.sv
// Round-robin read/write arbiter in front of a shared dual-port RAM.
// Clears the RAM after reset, then serves NREQ requesters on each port.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rd_req/rd_addr -> rd_gnt   read request side, combinational grant
//   rd_valid/rd_data           read return, one cycle after grant
//   wr_req/wr_addr/wr_data     write request side
//   wr_gnt                     combinational write grant
//   init_busy                  high while the clear sweep runs
//   ram_*                      connection to the external RAM
module ram_dp_arbiter #(
    parameter int                   NREQ       = 4,
    parameter int                   DATAWIDTH  = 9,
    parameter int                   ADDRWIDTH  = 9,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           rd_req,
    input  logic [NREQ*ADDRWIDTH-1:0] rd_addr,
    output logic [NREQ-1:0]           rd_gnt,
    output logic [NREQ-1:0]           rd_valid,
    output logic [DATAWIDTH-1:0]      rd_data,
    input  logic [NREQ-1:0]           wr_req,
    input  logic [NREQ*ADDRWIDTH-1:0] wr_addr,
    input  logic [NREQ*DATAWIDTH-1:0] wr_data,
    output logic [NREQ-1:0]           wr_gnt,
    output logic                      init_busy,
    output logic [ADDRWIDTH-1:0]      ram_rd_addr,
    input  logic [DATAWIDTH-1:0]      ram_rd_data,
    output logic [ADDRWIDTH-1:0]      ram_wr_addr,
    output logic [DATAWIDTH-1:0]      ram_wr_data,
    output logic                      ram_we
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDRWIDTH-1:0] cnt;
    logic [ADDRWIDTH-1:0] cnt_nxt;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        rd_ptr_nxt;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        wr_ptr_nxt;
    logic [ADDRWIDTH-1:0] rd_addr_q;

    // Two passes: indices at/after the pointer first, then the wrap-around.
    function automatic logic [NREQ-1:0] rr_pick(
        input logic [NREQ-1:0] req,
        input logic [PW-1:0]   ptr
    );
        logic [NREQ-1:0] g;
        logic            found;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                g[i]  = 1'b1;
                found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                g[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    assign rd_data = ram_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            cnt       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            rd_valid  <= '0;
            rd_addr_q <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_valid  <= rd_gnt;
            // Remember the last presented address so it holds when idle.
            rd_addr_q <= ram_rd_addr;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rd_ptr_nxt  = rd_ptr;
        wr_ptr_nxt  = wr_ptr;
        rd_gnt      = '0;
        wr_gnt      = '0;
        init_busy   = 1'b0;
        ram_rd_addr = rd_addr_q;
        ram_wr_addr = '0;
        ram_wr_data = INIT_VALUE;
        ram_we      = 1'b0;
        unique case (state)
            INIT: begin
                init_busy   = 1'b1;
                ram_we      = 1'b1;
                ram_rd_addr = cnt;
                ram_wr_addr = cnt;
                cnt_nxt     = cnt + ADDRWIDTH'(1);
                if (cnt == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rd_gnt = rr_pick(rd_req, rd_ptr);
                wr_gnt = rr_pick(wr_req, wr_ptr);
                for (int i = 0; i < NREQ; i++) begin
                    if (rd_gnt[i]) begin
                        ram_rd_addr = rd_addr[i*ADDRWIDTH +: ADDRWIDTH];
                        rd_ptr_nxt  = (i == NREQ - 1) ? '0 : PW'(i + 1);
                    end
                    if (wr_gnt[i]) begin
                        ram_we      = 1'b1;
                        ram_wr_addr = wr_addr[i*ADDRWIDTH +: ADDRWIDTH];
                        ram_wr_data = wr_data[i*DATAWIDTH +: DATAWIDTH];
                        wr_ptr_nxt  = (i == NREQ - 1) ? '0 : PW'(i + 1);
                    end
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Bench for ram_dp_arbiter: directed scenarios plus random traffic
// checked against an array-and-pointer reference model.
module tb_ram_dp_arbiter;

    localparam int N     = 4;
    localparam int DW    = 9;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    rd_req;
    logic [N-1:0]    wr_req;
    logic [N-1:0]    rd_gnt;
    logic [N-1:0]    rd_valid;
    logic [N-1:0]    wr_gnt;
    logic [N*AW-1:0] rd_addr;
    logic [N*AW-1:0] wr_addr;
    logic [N*DW-1:0] wr_data;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   ram_rd_data;
    logic [DW-1:0]   ram_wr_data;
    logic [AW-1:0]   ram_rd_addr;
    logic [AW-1:0]   ram_wr_addr;
    logic            ram_we;
    logic            init_busy;

    logic [AW-1:0] ra [N];
    logic [AW-1:0] wa [N];
    logic [DW-1:0] wd [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rd_addr[i*AW +: AW] = ra[i];
            wr_addr[i*AW +: AW] = wa[i];
            wr_data[i*DW +: DW] = wd[i];
        end
    end

    ram_dp_arbiter #(
        .NREQ(N), .DATAWIDTH(DW), .ADDRWIDTH(AW), .INIT_VALUE('0)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .init_busy(init_busy),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_we(ram_we)
    );

    // External RAM: registered read address; the write lands before the
    // read mux looks, so same-cycle write/read returns the new word.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [AW-1:0] ram_ra_q;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_wr_addr] <= ram_wr_data;
        ram_ra_q <= ram_rd_addr;
    end
    assign ram_rd_data = ram_mem[ram_ra_q];

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem_ref [DEPTH];
    int            rptr;
    int            wptr;
    int            last_rg;
    int            last_wg;
    logic [N-1:0]  exp_vmask;
    logic [DW-1:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rptr      = 0;
        wptr      = 0;
        exp_vmask = '0;
        exp_data  = '0;
        for (int d = 0; d < DEPTH; d++) mem_ref[d] = '0;
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (req[j[1:0]]) return j;
        end
        return -1;
    endfunction

    // One RUN cycle: check DUT against the model, advance model, clock.
    task automatic step();
        logic [N-1:0] eg;
        logic [N-1:0] ewg;
        int rg;
        int wg;
        #1;
        rg  = pick(rd_req, rptr);
        wg  = pick(wr_req, wptr);
        eg  = '0;
        ewg = '0;
        if (rg >= 0) eg[rg[1:0]] = 1'b1;
        if (wg >= 0) ewg[wg[1:0]] = 1'b1;
        chk("rd_valid", rd_valid, exp_vmask);
        if (exp_vmask != 0) chk("rd_data", rd_data, exp_data);
        chk("rd_gnt", rd_gnt, eg);
        chk("wr_gnt", wr_gnt, ewg);
        chk("ram_we", ram_we, wg >= 0);
        if (rg >= 0) chk("ram_rd_addr", ram_rd_addr, ra[rg[1:0]]);
        if (wg >= 0) begin
            chk("ram_wr_addr", ram_wr_addr, wa[wg[1:0]]);
            chk("ram_wr_data", ram_wr_data, wd[wg[1:0]]);
            mem_ref[wa[wg[1:0]]] = wd[wg[1:0]];
            wptr = (wg + 1) % N;
        end
        exp_vmask = eg;
        if (rg >= 0) begin
            exp_data = mem_ref[ra[rg[1:0]]];
            rptr     = (rg + 1) % N;
        end
        last_rg = rg;
        last_wg = wg;
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            chk("sweep_busy", init_busy, 1);
            chk("sweep_we", ram_we, 1);
            chk("sweep_wr_addr", ram_wr_addr, k);
            chk("sweep_rd_addr", ram_rd_addr, k);
            chk("sweep_rd_gnt", rd_gnt, 0);
            chk("sweep_wr_gnt", wr_gnt, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        rd_req = '0;
        wr_req = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            wa[i] = '0;
            wd[i] = '0;
        end
        model_reset();

        // Reset state, with requester 3 already asking for address 5.
        @(posedge clk);
        #1;
        chk("rst_busy", init_busy, 1);
        chk("rst_valid", rd_valid, 0);
        chk("rst_we", ram_we, 1);
        chk("rst_wr_addr", ram_wr_addr, 0);
        chk("rst_gnt", rd_gnt, 0);
        rd_req[3] = 1'b1;
        ra[3]     = 9'd5;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_sweep(DEPTH);

        #1;
        chk("busy_fell", init_busy, 0);
        chk("first_run_gnt", rd_gnt, 4'b1000);
        step();
        rd_req = '0;
        step();

        // Single read latency.
        wr_req = 4'b0100;
        wa[2]  = 9'h033;
        wd[2]  = 9'h1A5;
        step();
        wr_req = '0;
        rd_req = 4'b0100;
        ra[2]  = 9'h033;
        #1;
        chk("lat_gnt", rd_gnt, 4'b0100);
        chk("lat_early", rd_valid, 0);
        step();
        rd_req = '0;
        chk("lat_valid", rd_valid, 4'b0100);
        chk("lat_data", rd_data, 9'h1A5);
        step();
        chk("lat_once", rd_valid, 0);

        // Round robin from rd_ptr = 0.
        rd_req = 4'b1000;
        ra[3]  = 9'd0;
        step();
        for (int i = 0; i < N; i++) ra[i] = AW'(i);
        rd_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_gnt", rd_gnt, 1 << (k % 4));
            if (k > 0) chk("rr_valid", rd_valid, 1 << ((k - 1) % 4));
            step();
        end
        rd_req = '0;
        chk("rr_last_valid", rd_valid, 4'b1000);
        step();

        // Same-cycle write/read to one address.
        wr_req = 4'b0001;
        wa[0]  = 9'd7;
        wd[0]  = 9'h0FF;
        rd_req = 4'b0010;
        ra[1]  = 9'd7;
        step();
        wr_req = '0;
        rd_req = '0;
        chk("hz_valid", rd_valid, 4'b0010);
        chk("hz_data", rd_data, 9'h0FF);
        step();

        // Reset while a read is in flight.
        rd_req = 4'b0001;
        ra[0]  = 9'd7;
        reset  = 1'b1;
        step();
        rd_req = '0;
        chk("rst_run_valid", rd_valid, 0);
        chk("rst_run_busy", init_busy, 1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-sweep restarts at address 0.
        run_sweep(100);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_addr", ram_wr_addr, 0);
        chk("restart_busy", init_busy, 1);
        reset = 1'b0;
        run_sweep(DEPTH);

        // Random traffic on a small address window to provoke hazards.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rd_req[i[1:0]]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rd_req[i[1:0]] = 1'b1;
                        ra[i[1:0]]     = AW'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rd_req[i[1:0]] = 1'b0;
                end
                if (!wr_req[i[1:0]]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        wr_req[i[1:0]] = 1'b1;
                        wa[i[1:0]]     = AW'($urandom_range(0, 15));
                        wd[i[1:0]]     = DW'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    wr_req[i[1:0]] = 1'b0;
                end
            end
            step();
            if (last_rg >= 0) rd_req[last_rg[1:0]] = 1'b0;
            if (last_wg >= 0) wr_req[last_wg[1:0]] = 1'b0;
        end
        rd_req = '0;
        wr_req = '0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
